// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined register-file/ALU execute core.
// Opcodes, default widths and immediate sign extension.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREGS_DEF  = 4;
  localparam int IMM_W_DEF  = 9;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_EQ    = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  // Sign-extend the low w bits of v to 64 bits (1 <= w <= 64).
  function automatic logic [63:0] sext(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] t;
    t = v << (64 - w);
    return $signed(t) >>> (64 - w);
  endfunction

endpackage

// File: rtl/alu_regfile_pipe_alu_core.sv
// Combinational ALU: result, signed overflow and zero flag.
// Overflow is reported only for add, sub and eq.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_res,
  output logic              o_ovf,
  output logic              o_zero
);

  localparam int M = DATA_W - 1;

  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_add_v;
  logic              w_sub_v;
  logic              w_slt;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;

  assign w_add_v = (i_a[M] == i_b[M]) &&
                   (w_sum[M] != i_a[M]);
  assign w_sub_v = (i_a[M] != i_b[M]) &&
                   (w_diff[M] != i_a[M]);

  assign w_slt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_res = '0;
    o_ovf = 1'b0;
    unique case (i_op)
      ALU_ADD: begin
        o_res = w_sum;
        o_ovf = w_add_v;
      end
      ALU_SUB: begin
        o_res = w_diff;
        o_ovf = w_sub_v;
      end
      ALU_AND: o_res = i_a & i_b;
      ALU_OR:  o_res = i_a | i_b;
      ALU_XOR: o_res = i_a ^ i_b;
      ALU_SLT: o_res = {{M{1'b0}}, w_slt};
      ALU_EQ: begin
        o_res = w_diff;
        o_ovf = w_sub_v;
      end
      ALU_PASSB: o_res = i_b;
    endcase
  end

  assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_regfile_pipe.sv
// Two-stage execute core: ID operand read/forward, EX ALU + writeback.
// One write port shared by pipeline writeback and an external loader.
module alu_regfile_pipe
  import alu_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int NREGS  = NREGS_DEF,
  parameter  int IMM_W  = IMM_W_DEF,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic              alu_src0,
  input  logic              alu_src1,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        alu_op,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              ext_wr_valid,
  output logic              ext_wr_ready,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  output logic              res_valid,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              zero
);

  logic [DATA_W-1:0] r_regs [NREGS];

  logic              r_ex_valid;
  logic [2:0]        r_ex_op;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic              r_ex_wb_en;
  logic [ADDR_W-1:0] r_ex_wb_addr;

  logic              r_res_valid;
  logic [DATA_W-1:0] r_result;
  logic              r_ovf;
  logic              r_zero;

  logic              w_ex_wb;
  logic              w_ext_fire;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_ovf;
  logic              w_alu_zero;
  logic [63:0]       w_imm64;

  assign w_ex_wb      = r_ex_valid && r_ex_wb_en;
  assign ext_wr_ready = !w_ex_wb;
  assign w_ext_fire   = ext_wr_valid && ext_wr_ready;

  // Truncation covers IMM_W >= DATA_W.
  assign w_imm64 = sext(64'(imm), IMM_W);
  assign w_imm   = w_imm64[DATA_W-1:0];

  // EX result outranks loader data; both only when the mux selects a register.
  always_comb begin
    w_op_a = r_regs[rd0_addr];
    if (alu_src0)
      w_op_a = '0;
    else if (w_ex_wb && r_ex_wb_addr == rd0_addr)
      w_op_a = w_alu_res;
    else if (w_ext_fire && ext_wr_addr == rd0_addr)
      w_op_a = ext_wr_data;
  end

  always_comb begin
    w_op_b = r_regs[rd1_addr];
    if (alu_src1)
      w_op_b = w_imm;
    else if (w_ex_wb && r_ex_wb_addr == rd1_addr)
      w_op_b = w_alu_res;
    else if (w_ext_fire && ext_wr_addr == rd1_addr)
      w_op_b = ext_wr_data;
  end

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op   (r_ex_op),
    .i_a    (r_ex_a),
    .i_b    (r_ex_b),
    .o_res  (w_alu_res),
    .o_ovf  (w_alu_ovf),
    .o_zero (w_alu_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_op      <= ALU_ADD;
      r_ex_a       <= '0;
      r_ex_b       <= '0;
      r_ex_wb_en   <= 1'b0;
      r_ex_wb_addr <= '0;
    end else begin
      r_ex_valid <= issue_valid;
      if (issue_valid) begin
        r_ex_op      <= alu_op;
        r_ex_a       <= w_op_a;
        r_ex_b       <= w_op_b;
        r_ex_wb_en   <= wb_en;
        r_ex_wb_addr <= wb_addr;
      end
    end
  end

  // Outputs hold their last values across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_res_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_result <= w_alu_res;
        r_ovf    <= w_alu_ovf;
        r_zero   <= w_alu_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else if (w_ex_wb) begin
      r_regs[r_ex_wb_addr] <= w_alu_res;
    end else if (w_ext_fire) begin
      r_regs[ext_wr_addr] <= ext_wr_data;
    end
  end

  assign res_valid = r_res_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Bench for alu_regfile_pipe: directed plan plus random traffic
// against a sequential architectural model.
module tb_alu_regfile_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [1:0] rd0_addr;
  logic [1:0] rd1_addr;
  logic       alu_src0;
  logic       alu_src1;
  logic [8:0] imm;
  logic [2:0] alu_op;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic       ext_wr_valid;
  logic       ext_wr_ready;
  logic [1:0] ext_wr_addr;
  logic [7:0] ext_wr_data;
  logic       res_valid;
  logic [7:0] result;
  logic       ovf;
  logic       zero;

  always #5 clk = ~clk;

  alu_regfile_pipe #(
    .DATA_W (8),
    .NREGS  (4),
    .IMM_W  (9)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .rd0_addr     (rd0_addr),
    .rd1_addr     (rd1_addr),
    .alu_src0     (alu_src0),
    .alu_src1     (alu_src1),
    .imm          (imm),
    .alu_op       (alu_op),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .ext_wr_valid (ext_wr_valid),
    .ext_wr_ready (ext_wr_ready),
    .ext_wr_addr  (ext_wr_addr),
    .ext_wr_data  (ext_wr_data),
    .res_valid    (res_valid),
    .result       (result),
    .ovf          (ovf),
    .zero         (zero)
  );

  typedef struct {
    bit rs;
    bit iv;
    int a0;
    int a1;
    bit s0;
    bit s1;
    int im;
    int op;
    bit we;
    int wa;
    bit ev;
    int ea;
    int ed;
  } stim_t;

  typedef struct {
    bit v;
    int r;
    bit o;
    bit z;
    bit wb;
  } exp_t;

  int   n_chk = 0;
  int   n_pass = 0;
  int   m_regs [4];
  exp_t p1;
  exp_t p2;
  int   l_r;
  bit   l_o;
  bit   l_z;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic int to_s(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Architectural ALU on plain integers.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output bit o);
    int s;
    o = 1'b0;
    case (op)
      0: begin
        s = to_s(a) + to_s(b);
        r = (a + b) & 255;
        o = (s > 127) || (s < -128);
      end
      1, 6: begin
        s = to_s(a) - to_s(b);
        r = (a - b) & 255;
        o = (s > 127) || (s < -128);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (to_s(a) < to_s(b)) ? 1 : 0;
      default: r = b;
    endcase
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic stim_t op_s(int op, int a0, int a1, bit s0, bit s1,
                                 int im, bit we, int wa);
    stim_t s;
    s = nop();
    s.iv = 1; s.op = op; s.a0 = a0; s.a1 = a1;
    s.s0 = s0; s.s1 = s1; s.im = im; s.we = we; s.wa = wa;
    return s;
  endfunction

  function automatic stim_t ext_s(int ea, int ed);
    stim_t s;
    s = nop();
    s.ev = 1; s.ea = ea; s.ed = ed;
    return s;
  endfunction

  function automatic stim_t rst_s();
    stim_t s;
    s = nop();
    s.rs = 1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst          = s.rs;
    issue_valid  = s.iv;
    rd0_addr     = 2'(s.a0);
    rd1_addr     = 2'(s.a1);
    alu_src0     = s.s0;
    alu_src1     = s.s1;
    imm          = 9'(s.im);
    alu_op       = 3'(s.op);
    wb_en        = s.we;
    wb_addr      = 2'(s.wa);
    ext_wr_valid = s.ev;
    ext_wr_addr  = 2'(s.ea);
    ext_wr_data  = 8'(s.ed);
  endtask

  // One cycle: check outputs, drive s, advance the model.
  task automatic cyc(input stim_t s);
    bit exp_rdy;
    int a;
    int b;
    int r;
    bit o;
    @(negedge clk);
    exp_rdy = !(p1.v && p1.wb);
    chk("ready", ext_wr_ready, exp_rdy);
    chk("valid", res_valid, p2.v);
    if (p2.v) begin
      l_r = p2.r; l_o = p2.o; l_z = p2.z;
    end
    chk("result", result, l_r);
    chk("ovf", ovf, l_o);
    chk("zero", zero, l_z);
    drive(s);
    p2 = p1;
    p1 = '{default: 0};
    if (s.rs) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      p2 = '{default: 0};
      l_r = 0; l_o = 0; l_z = 0;
    end else begin
      if (s.ev && exp_rdy) m_regs[s.ea] = s.ed;
      if (s.iv) begin
        a = s.s0 ? 0 : m_regs[s.a0];
        b = s.s1 ? (((s.im > 255) ? s.im - 512 : s.im) & 255)
                 : m_regs[s.a1];
        ref_alu(s.op, a, b, r, o);
        p1.v = 1; p1.r = r; p1.o = o;
        p1.z = (r == 0); p1.wb = s.we;
        if (s.we) m_regs[s.wa] = r;
      end
    end
  endtask

  // Result of the op issued two cyc() calls ago.
  task automatic see(input string tag, input int r, input bit o,
                     input bit z);
    @(posedge clk);
    #1;
    chk({tag, "_v"}, res_valid, 1);
    chk({tag, "_r"}, result, r);
    chk({tag, "_o"}, ovf, o);
    chk({tag, "_z"}, zero, z);
  endtask

  stim_t st;

  initial begin
    p1 = '{default: 0};
    p2 = '{default: 0};
    l_r = 0; l_o = 0; l_z = 0;
    foreach (m_regs[i]) m_regs[i] = 0;
    drive(rst_s());

    cyc(rst_s());
    cyc(rst_s());
    cyc(nop());
    chk("rst_ready", ext_wr_ready, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_result", result, 0);

    for (int i = 0; i < 4; i++) cyc(op_s(7, 0, i, 0, 0, 0, 0, 0));
    cyc(nop());
    cyc(nop());

    cyc(ext_s(0, 8'hFF));
    cyc(ext_s(1, 8'h55));
    cyc(ext_s(2, 8'hAA));
    cyc(ext_s(3, 8'h7F));
    cyc(op_s(2, 1, 2, 0, 0, 0, 0, 0));
    cyc(op_s(3, 1, 2, 0, 0, 0, 0, 0));
    see("and", 8'h00, 0, 1);
    cyc(op_s(0, 3, 1, 0, 0, 0, 0, 0));
    see("or", 8'hFF, 0, 0);
    cyc(op_s(6, 1, 1, 0, 0, 0, 0, 0));
    see("add", 8'hD4, 1, 0);
    cyc(op_s(5, 1, 3, 0, 0, 0, 0, 0));
    see("eq", 8'h00, 0, 1);
    cyc(op_s(0, 0, 0, 1, 1, 9'h00F, 1, 2));
    see("slt", 8'h01, 0, 0);
    cyc(op_s(0, 2, 1, 0, 0, 0, 0, 0));
    see("imm", 8'h0F, 0, 0);
    cyc(op_s(7, 0, 2, 0, 0, 0, 0, 0));
    see("byp", 8'h64, 0, 0);
    cyc(nop());
    see("r2", 8'h0F, 0, 0);

    cyc(op_s(7, 0, 0, 0, 0, 0, 1, 0));
    cyc(ext_s(3, 8'h11));
    chk("arb_busy", ext_wr_ready, 0);
    cyc(ext_s(3, 8'h11));
    chk("arb_free", ext_wr_ready, 1);
    cyc(op_s(7, 0, 3, 0, 0, 0, 0, 0));
    cyc(nop());
    see("arb_r3", 8'h11, 0, 0);

    cyc(op_s(0, 0, 0, 1, 1, 9'h033, 1, 0));
    cyc(rst_s());
    @(posedge clk);
    #1;
    chk("mid_rst_valid", res_valid, 0);
    cyc(nop());
    chk("mid_rst_valid2", res_valid, 0);
    cyc(op_s(7, 0, 0, 0, 0, 0, 0, 0));
    cyc(nop());
    see("mid_rst_r0", 8'h00, 0, 1);

    for (int i = 0; i < 600; i++) begin
      st = nop();
      st.rs = ($urandom_range(0, 79) == 0);
      st.iv = ($urandom_range(0, 3) != 0);
      st.a0 = $urandom_range(0, 3);
      st.a1 = $urandom_range(0, 3);
      st.s0 = ($urandom_range(0, 3) == 0);
      st.s1 = ($urandom_range(0, 2) == 0);
      st.im = $urandom_range(0, 511);
      st.op = $urandom_range(0, 7);
      st.we = ($urandom_range(0, 2) != 0);
      st.wa = $urandom_range(0, 3);
      st.ev = ($urandom_range(0, 2) == 0);
      st.ea = $urandom_range(0, 3);
      st.ed = $urandom_range(0, 255);
      cyc(st);
    end
    cyc(nop());
    cyc(nop());
    cyc(nop());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
